// File: rtl/bram_to_axi_rd_pkg.sv
// bram_to_axi_rd_pkg: shared burst/response encodings and FSM state type
package bram_to_axi_rd_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

endpackage

// File: rtl/rd_skid_fifo.sv
// rd_skid_fifo: small circular FIFO holding returned read beats ahead of the R channel
module rd_skid_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    assign dout_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

    // Storage is data-only and needs no reset; validity lives in cnt_q
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves occupancy unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
            if (do_pop)  rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/bram_to_axi_rd.sv
// bram_to_axi_rd: AXI4 read slave serving single bursts from a BRAM port with credit-limited issue
module bram_to_axi_rd
    import bram_to_axi_rd_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH     = 16,
    parameter int C_S_AXI_DATA_WIDTH   = 128,
    parameter int C_S_AXI_ADDR_WIDTH   = 14,
    parameter int C_S_AXI_ARUSER_WIDTH = 8,
    parameter int BRAM_RD_LATENCY      = 1
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                        S_AXI_ARLEN,
    input  logic [1:0]                        S_AXI_ARBURST,
    input  logic [C_S_AXI_ARUSER_WIDTH-1:0]   S_AXI_ARUSER,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RLAST,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              bram_clk,
    output logic                              bram_rst,
    output logic                              bram_en,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     bram_addr,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   bram_we,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     bram_din,
    output logic                              rd_start,
    output logic [C_S_AXI_ARUSER_WIDTH-1:0]   size,
    input  logic                              data_ready
);

    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int LAT   = BRAM_RD_LATENCY;
    localparam int DEPTH = LAT + 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int LSB   = $clog2(DW / 8);
    localparam logic [AW-1:0] ONE  = AW'(1);
    localparam logic [AW-1:0] STEP = AW'(DW / 8);

    state_e                          state_q, state_d;
    logic                            arready_q, arready_d;
    logic [C_S_AXI_ID_WIDTH-1:0]     id_q, id_d;
    logic [7:0]                      len_q, len_d;
    logic [1:0]                      burst_q, burst_d;
    logic [C_S_AXI_ARUSER_WIDTH-1:0] size_q, size_d;
    logic [AW-1:0]                   addr_q, addr_d;
    logic [8:0]                      issued_q, issued_d;
    logic                            rd_start_q;
    logic [LAT-1:0]                  pv_q;
    logic [LAT-1:0]                  pl_q;

    logic            ar_hs, r_hs, done, err, issue, rvalid;
    logic [CW-1:0]   cnt, infl;
    logic [CW:0]     credit;
    logic [DW:0]     head;
    logic [AW-1:0]   wrap_mask, next_addr;

    assign ar_hs     = S_AXI_ARVALID && arready_q;
    assign err       = (burst_q == BURST_RSVD);
    assign r_hs      = rvalid && S_AXI_RREADY;
    assign done      = r_hs && head[DW];
    assign credit    = (CW + 1)'(cnt) - (CW + 1)'(r_hs) + (CW + 1)'(infl);
    assign issue     = (state_q == ST_BURST) && (issued_q <= {1'b0, len_q}) && data_ready &&
                       (credit < (CW + 1)'(DEPTH));
    assign wrap_mask = ((AW'(len_q) + ONE) << LSB) - ONE;
    assign next_addr = (burst_q == BURST_FIXED) ? addr_q :
                       (burst_q == BURST_WRAP)  ? ((addr_q & ~wrap_mask) | ((addr_q + STEP) & wrap_mask)) :
                                                  addr_q + STEP;

    // Reads still travelling through the BRAM pipeline count against FIFO space
    always_comb begin
        infl = '0;
        for (int i = 0; i < LAT; i++) infl = infl + CW'(pv_q[i]);
    end

    // Next state: accept AR, advance address/beat count per issued read, retire on final beat
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        len_d    = len_q;
        burst_d  = burst_q;
        size_d   = size_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        if (ar_hs) begin
            state_d  = ST_BURST;
            id_d     = S_AXI_ARID;
            len_d    = S_AXI_ARLEN;
            burst_d  = S_AXI_ARBURST;
            size_d   = S_AXI_ARUSER;
            addr_d   = S_AXI_ARADDR & ~(STEP - ONE);
            issued_d = '0;
        end else begin
            if (issue) begin
                addr_d   = next_addr;
                issued_d = issued_q + 9'd1;
            end
            if (done) begin
                state_d = ST_IDLE;
                size_d  = '0;
            end
        end
        arready_d = (state_d == ST_IDLE);
    end

    // Control registers; ARREADY stays low through reset and rises on the first edge after
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q    <= ST_IDLE;
            arready_q  <= 1'b0;
            id_q       <= '0;
            len_q      <= '0;
            burst_q    <= '0;
            size_q     <= '0;
            addr_q     <= '0;
            issued_q   <= '0;
            rd_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            arready_q  <= arready_d;
            id_q       <= id_d;
            len_q      <= len_d;
            burst_q    <= burst_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            issued_q   <= issued_d;
            rd_start_q <= ar_hs;
        end
    end

    // Delay line matching BRAM latency: marks when bram_din is valid and whether it is the last beat
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            pv_q <= '0;
            pl_q <= '0;
        end else begin
            pv_q[0] <= issue;
            pl_q[0] <= (issued_q == {1'b0, len_q});
            for (int i = 1; i < LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pl_q[i] <= pl_q[i-1];
            end
        end
    end

    rd_skid_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .push_i  (pv_q[LAT-1]),
        .din_i   ({pl_q[LAT-1], err ? {DW{1'b0}} : bram_din}),
        .pop_i   (r_hs),
        .dout_o  (head),
        .empty_o (),
        .count_o (cnt)
    );

    assign rvalid        = (cnt != '0);
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rvalid ? head[DW-1:0] : '0;
    assign S_AXI_RLAST   = rvalid && head[DW];
    assign S_AXI_RRESP   = (rvalid && err) ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI_RID     = id_q;
    assign bram_clk      = S_AXI_ACLK;
    assign bram_rst      = ~S_AXI_ARESETN;
    assign bram_en       = issue && !err;
    assign bram_addr     = addr_q;
    assign bram_we       = '0;
    assign rd_start      = rd_start_q;
    assign size          = size_q;

endmodule

// File: tb/tb_bram_to_axi_rd.sv
// tb_bram_to_axi_rd: randomized and directed checks of bram_to_axi_rd against a burst-level model
module tb_bram_to_axi_rd;

    localparam int IDW = 16;
    localparam int DW  = 128;
    localparam int AW  = 14;
    localparam int UW  = 8;
    typedef logic [IDW+2+1+DW-1:0] beat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [IDW-1:0]  arid = '0;
    logic [AW-1:0]   araddr = '0;
    logic [7:0]      arlen = '0;
    logic [1:0]      arburst = '0;
    logic [UW-1:0]   aruser = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [IDW-1:0]  rid;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast, rvalid;
    logic            rready = 1'b0;
    logic            bram_clk, bram_rst, bram_en;
    logic [AW-1:0]   bram_addr;
    logic [DW/8-1:0] bram_we;
    logic [DW-1:0]   bram_din = '0;
    logic            rd_start;
    logic [UW-1:0]   size;
    logic            data_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int first_rv, stab_viol, gap_en, early_ar, rd_cnt, size_bad;
    logic mon_on = 1'b0, done = 1'b0, gap_active = 1'b0, prev_stall = 1'b0;
    beat_t held;
    beat_t got_beat[$];
    logic [AW-1:0] en_addr[$];
    int beat_cyc[$];

    bram_to_axi_rd dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_ARID    (arid),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARLEN   (arlen),
        .S_AXI_ARBURST (arburst),
        .S_AXI_ARUSER  (aruser),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RID     (rid),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RLAST   (rlast),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .bram_clk      (bram_clk),
        .bram_rst      (bram_rst),
        .bram_en       (bram_en),
        .bram_addr     (bram_addr),
        .bram_we       (bram_we),
        .bram_din      (bram_din),
        .rd_start      (rd_start),
        .size          (size),
        .data_ready    (data_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] bram_data(input logic [AW-1:0] a);
        logic [31:0] x;
        x = 32'(a);
        return {x * 32'h9E3779B1, x ^ 32'h1234_5678, x + 32'h0BAD_0000, ~x};
    endfunction

    // Latency-1 BRAM with deterministic contents
    always @(posedge clk) if (bram_en) bram_din <= bram_data(bram_addr);

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a, input logic [7:0] len,
                                               input logic [1:0] bt, input int i);
        int s, w, lo;
        s = int'(a) & ~15;
        w = (int'(len) + 1) * 16;
        if (bt == 2'b00) return AW'(s);
        if (bt == 2'b10) begin
            lo = (s / w) * w;
            return AW'(lo + (s - lo + i * 16) % w);
        end
        return AW'(s + i * 16);
    endfunction

    function automatic beat_t exp_beat(input logic [IDW-1:0] id, input logic [AW-1:0] a,
                                       input logic [7:0] len, input logic [1:0] bt, input int i);
        if (bt == 2'b11) return {id, 2'b10, i == int'(len), {DW{1'b0}}};
        return {id, 2'b00, i == int'(len), bram_data(exp_addr(a, len, bt, i))};
    endfunction

    always @(negedge clk) if (mon_on) begin
        if (bram_en) en_addr.push_back(bram_addr);
        if (bram_en && gap_active) gap_en++;
        if (rd_start) rd_cnt++;
        if (!done && arready) early_ar++;
        if (!done && size !== aruser) size_bad++;
        if (rvalid && first_rv < 0) first_rv = cyc - hs_cyc;
        if (prev_stall && rvalid && {rid, rresp, rlast, rdata} !== held) stab_viol++;
        prev_stall = rvalid && !rready;
        held = {rid, rresp, rlast, rdata};
        if (rvalid && rready) begin
            got_beat.push_back(held);
            beat_cyc.push_back(cyc);
            if (rlast) done = 1'b1;
        end
    end

    // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random; stop_after=0 runs to RLAST
    task automatic run_burst(input logic [IDW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                             input logic [1:0] bt, input int rmode, input int gap_at, input int gap_len,
                             input int stop_after);
        int t, rel;
        en_addr.delete();
        got_beat.delete();
        beat_cyc.delete();
        first_rv = -1; stab_viol = 0; gap_en = 0; early_ar = 0; rd_cnt = 0; size_bad = 0;
        done = 1'b0; prev_stall = 1'b0;
        arid = id; araddr = a; arlen = len; arburst = bt; aruser = UW'($urandom); arvalid = 1'b1;
        t = 0;
        while (arready !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        hs_cyc = cyc;
        arvalid = 1'b0;
        mon_on = 1'b1;
        rel = 0;
        while (!done && (stop_after == 0 || got_beat.size() < stop_after) && rel < 600) begin
            rel = cyc - hs_cyc;
            rready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((rel % 4 == 0) || (rel % 4 == 3)) : 1'($urandom_range(0, 1));
            data_ready = !(rel >= gap_at && rel < gap_at + gap_len);
            gap_active = !data_ready;
            @(posedge clk); #1;
        end
        mon_on = 1'b0;
        data_ready = 1'b1;
        gap_active = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({arready, rvalid, rlast, rresp, rid, rdata, bram_en, bram_addr, rd_start, size, bram_we} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got arready=%b rvalid=%b en=%b addr=%h size=%h", arready, rvalid, bram_en, bram_addr, size);
        end
        checks++;
        if (bram_rst !== 1'b1 || bram_clk !== clk) begin
            errors++;
            $display("FAIL reset_bram_pins got rst=%b clk=%b exp rst=1 clk=%b", bram_rst, bram_clk, clk);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if (arready !== 1'b0) begin errors++; $display("FAIL reset_arready_pre got %b exp 0", arready); end
        @(posedge clk); #1;
        checks++;
        if (arready !== 1'b1) begin errors++; $display("FAIL reset_arready_rise got %b exp 1", arready); end
    endtask

    task automatic test_incr();
        logic [AW-1:0] ea [4];
        ea = '{14'h100, 14'h110, 14'h120, 14'h130};
        run_burst(16'h1234, 14'h0100, 8'd3, 2'b01, 0, 0, 0, 0);
        checks++;
        if (en_addr.size() != 4) begin errors++; $display("FAIL incr_en_count got %0d exp 4", en_addr.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (en_addr[i] !== ea[i]) begin errors++; $display("FAIL incr_addr%0d got %h exp %h", i, en_addr[i], ea[i]); end
        end
        checks++;
        if (got_beat.size() != 4) begin errors++; $display("FAIL incr_beats got %0d exp 4", got_beat.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_beat[i] !== exp_beat(16'h1234, 14'h0100, 8'd3, 2'b01, i)) begin
                errors++; $display("FAIL incr_beat%0d got %h exp %h", i, got_beat[i], exp_beat(16'h1234, 14'h0100, 8'd3, 2'b01, i));
            end
        end
        checks++;
        if (first_rv != 2) begin errors++; $display("FAIL incr_first_rvalid got %0d exp 2", first_rv); end
        checks++;
        if (beat_cyc.size() == 4 && beat_cyc[3] - beat_cyc[0] != 3) begin
            errors++; $display("FAIL incr_back_to_back got span %0d exp 3", beat_cyc[3] - beat_cyc[0]);
        end
        checks++;
        if (rd_cnt != 1) begin errors++; $display("FAIL incr_rd_start got %0d exp 1", rd_cnt); end
        checks++;
        if (size_bad != 0) begin errors++; $display("FAIL incr_size_held got %0d bad cycles exp 0", size_bad); end
        checks++;
        if (arready !== 1'b1 || size !== '0) begin errors++; $display("FAIL incr_idle_after got arready=%b size=%h exp 1/00", arready, size); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea [4];
        ea = '{14'h130, 14'h100, 14'h110, 14'h120};
        run_burst(16'h00AB, 14'h0130, 8'd3, 2'b10, 0, 0, 0, 0);
        checks++;
        if (en_addr.size() != 4) begin errors++; $display("FAIL wrap_en_count got %0d exp 4", en_addr.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (en_addr[i] !== ea[i]) begin errors++; $display("FAIL wrap_addr%0d got %h exp %h", i, en_addr[i], ea[i]); end
            checks++;
            if (got_beat[i] !== exp_beat(16'h00AB, 14'h0130, 8'd3, 2'b10, i)) begin
                errors++; $display("FAIL wrap_beat%0d got %h exp %h", i, got_beat[i], exp_beat(16'h00AB, 14'h0130, 8'd3, 2'b10, i));
            end
        end
    endtask

    task automatic test_backpressure();
        run_burst(16'h0777, 14'h0A40, 8'd7, 2'b01, 1, 0, 0, 0);
        checks++;
        if (got_beat.size() != 8) begin errors++; $display("FAIL bp_beats got %0d exp 8", got_beat.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_beat[i] !== exp_beat(16'h0777, 14'h0A40, 8'd7, 2'b01, i)) begin
                errors++; $display("FAIL bp_beat%0d got %h exp %h", i, got_beat[i], exp_beat(16'h0777, 14'h0A40, 8'd7, 2'b01, i));
            end
        end
        checks++;
        if (stab_viol != 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", stab_viol); end
    endtask

    task automatic test_data_ready_gap();
        run_burst(16'h5A5A, 14'h1F00, 8'd7, 2'b01, 0, 3, 5, 0);
        checks++;
        if (gap_en != 0) begin errors++; $display("FAIL gap_bram_en got %0d exp 0", gap_en); end
        checks++;
        if (early_ar != 0) begin errors++; $display("FAIL gap_arready_early got %0d exp 0", early_ar); end
        checks++;
        if (got_beat.size() != 8) begin errors++; $display("FAIL gap_beats got %0d exp 8", got_beat.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_beat[i] !== exp_beat(16'h5A5A, 14'h1F00, 8'd7, 2'b01, i)) begin
                errors++; $display("FAIL gap_beat%0d got %h exp %h", i, got_beat[i], exp_beat(16'h5A5A, 14'h1F00, 8'd7, 2'b01, i));
            end
        end
    endtask

    task automatic test_slverr();
        run_burst(16'hE001, 14'h0200, 8'd1, 2'b11, 0, 0, 0, 0);
        checks++;
        if (en_addr.size() != 0) begin errors++; $display("FAIL slverr_bram_en got %0d exp 0", en_addr.size()); end
        checks++;
        if (got_beat.size() != 2) begin errors++; $display("FAIL slverr_beats got %0d exp 2", got_beat.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_beat[i] !== exp_beat(16'hE001, 14'h0200, 8'd1, 2'b11, i)) begin
                errors++; $display("FAIL slverr_beat%0d got %h exp %h", i, got_beat[i], exp_beat(16'hE001, 14'h0200, 8'd1, 2'b11, i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int rv;
        run_burst(16'h3333, 14'h0800, 8'd7, 2'b01, 0, 0, 0, 2);
        checks++;
        if (got_beat.size() != 2) begin errors++; $display("FAIL rmid_pre_beats got %0d exp 2", got_beat.size()); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({arready, rvalid, rlast, rresp, rid, rdata, bram_en, bram_addr, rd_start, size} !== '0) begin
            errors++;
            $display("FAIL rmid_outputs got arready=%b rvalid=%b en=%b addr=%h rid=%h size=%h", arready, rvalid, bram_en, bram_addr, rid, size);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (arready !== 1'b1) begin errors++; $display("FAIL rmid_arready got %b exp 1", arready); end
        rv = 0;
        rready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rvalid || bram_en) rv++;
        end
        @(posedge clk); #1;
        checks++;
        if (rv != 0) begin errors++; $display("FAIL rmid_stale_beats got %0d exp 0", rv); end
        run_burst(16'hBEEF, 14'h0240, 8'd0, 2'b01, 0, 0, 0, 0);
        checks++;
        if (got_beat.size() != 1) begin errors++; $display("FAIL rmid_fresh_beats got %0d exp 1", got_beat.size()); end
        checks++;
        if (got_beat[0] !== exp_beat(16'hBEEF, 14'h0240, 8'd0, 2'b01, 0)) begin
            errors++; $display("FAIL rmid_fresh_beat got %h exp %h", got_beat[0], exp_beat(16'hBEEF, 14'h0240, 8'd0, 2'b01, 0));
        end
    endtask

    task automatic test_random();
        logic [IDW-1:0] id;
        logic [AW-1:0]  a;
        logic [7:0]     len;
        logic [1:0]     bt;
        int             n_en;
        for (int k = 0; k < 25; k++) begin
            id = IDW'($urandom);
            a  = AW'($urandom);
            bt = 2'($urandom_range(0, 3));
            len = (bt == 2'b10) ? 8'((2 << $urandom_range(0, 3)) - 1) : 8'($urandom_range(0, 15));
            run_burst(id, a, len, bt, 2, $urandom_range(0, 10), $urandom_range(0, 4), 0);
            n_en = (bt == 2'b11) ? 0 : int'(len) + 1;
            checks++;
            if (en_addr.size() != n_en || got_beat.size() != int'(len) + 1) begin
                errors++; $display("FAIL rnd%0d_counts got en=%0d beats=%0d exp en=%0d beats=%0d", k, en_addr.size(), got_beat.size(), n_en, int'(len) + 1);
            end
            for (int i = 0; i < en_addr.size(); i++) begin
                checks++;
                if (en_addr[i] !== exp_addr(a, len, bt, i)) begin
                    errors++; $display("FAIL rnd%0d_addr%0d got %h exp %h", k, i, en_addr[i], exp_addr(a, len, bt, i));
                end
            end
            for (int i = 0; i < got_beat.size(); i++) begin
                checks++;
                if (got_beat[i] !== exp_beat(id, a, len, bt, i)) begin
                    errors++; $display("FAIL rnd%0d_beat%0d got %h exp %h", k, i, got_beat[i], exp_beat(id, a, len, bt, i));
                end
            end
            checks++;
            if (stab_viol != 0 || early_ar != 0) begin
                errors++; $display("FAIL rnd%0d_protocol got stable_changes=%0d early_arready=%0d exp 0/0", k, stab_viol, early_ar);
            end
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_backpressure();
        test_data_ready_gap();
        test_slverr();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
